// File: rtl/usr_pkg.sv
// Shared definitions for the universal-shift-register command sequencer:
// opcodes, the queued command record, FSM states and the shift-in mapping.
package usr_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_SET  = 3'b100;
    localparam logic [2:0] OP_INC  = 3'b101;
    localparam logic [2:0] OP_DEC  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    // Width of the stored repeat field; the top's CNT_W defaults to this.
    localparam int USR_CNT_W = 4;

    typedef struct packed {
        logic [2:0]           op;
        logic [5:0]           data;
        logic [USR_CNT_W-1:0] rep;
        logic                 si;
    } usr_cmd_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } usr_state_e;

    // Returns {rsi, lsi}: the shift-in bit is routed only for the two shift opcodes.
    function automatic logic [1:0] shift_in_map(input logic [2:0] op, input logic si);
        logic [1:0] res;
        case (op)
            OP_SHL:  res = {si, 1'b0};
            OP_SHR:  res = {1'b0, si};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/usr_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; flush empties it in one edge.
module usr_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full && !flush;
    assign do_pop_s  = pop && !empty && !flush;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge Clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer driving A/D/RSI/LSI of the 6-bit universal shift register.
// Optional feature macro: USR_SEQ_ABORT_EN adds a synchronous abort/flush input.
module usr_cmd_sequencer
    import usr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = USR_CNT_W
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [5:0]       cmd_data,
    input  logic [CNT_W-1:0] cmd_rep,
    input  logic             cmd_si,
`ifdef USR_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [2:0]       A,
    output logic [5:0]       D,
    output logic             RSI,
    output logic             LSI,
    output logic             busy,
    output logic             cmd_done
);

    localparam int CW = $bits(usr_cmd_t);

    usr_state_e       state_r;
    usr_state_e       next_state_s;
    logic [CNT_W-1:0] rep_cnt_r;
    logic [CNT_W-1:0] load_rep_s;
    logic [2:0]       a_r;
    logic [5:0]       d_r;
    logic             rsi_r;
    logic             lsi_r;
    logic             done_r;
    logic             done_next_s;
    logic             pop_s;
    logic             dec_s;
    logic             hold_s;
    logic             push_s;
    logic             abort_s;
    logic             full_s;
    logic             empty_s;
    logic [1:0]       si_map_s;
    usr_cmd_t         wr_cmd_s;
    usr_cmd_t         head_s;
    logic [CW-1:0]    rd_data_s;

`ifdef USR_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign cmd_ready = !full_s && !abort_s;
    assign push_s    = cmd_valid && cmd_ready;
    assign wr_cmd_s  = '{op: cmd_op, data: cmd_data, rep: USR_CNT_W'(cmd_rep), si: cmd_si};
    assign head_s    = rd_data_s;
    assign load_rep_s = CNT_W'(head_s.rep);
    assign si_map_s  = shift_in_map(head_s.op, head_s.si);

    usr_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .Clk     (Clk),
        .reset   (reset),
        .flush   (abort_s),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (wr_cmd_s),
        .rd_data (rd_data_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Next-state and issue control; cmd_done is computed one cycle ahead so it registers onto the final issue cycle.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        dec_s        = 1'b0;
        hold_s       = 1'b0;
        done_next_s  = 1'b0;
        if (abort_s) begin
            next_state_s = ST_IDLE;
            hold_s       = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        next_state_s = ST_ISSUE;
                        done_next_s  = (load_rep_s == {CNT_W{1'b0}});
                    end else begin
                        hold_s = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (rep_cnt_r != {CNT_W{1'b0}}) begin
                        dec_s       = 1'b1;
                        done_next_s = (rep_cnt_r == CNT_W'(1));
                    end else if (!empty_s) begin
                        // Chain straight into the next command without a Hold cycle.
                        pop_s       = 1'b1;
                        done_next_s = (load_rep_s == {CNT_W{1'b0}});
                    end else begin
                        next_state_s = ST_IDLE;
                        hold_s       = 1'b1;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                    hold_s       = 1'b1;
                end
            endcase
        end
    end

    // State, repeat counter and registered shift-register controls.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            rep_cnt_r <= {CNT_W{1'b0}};
            a_r       <= OP_HOLD;
            d_r       <= 6'h00;
            rsi_r     <= 1'b0;
            lsi_r     <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            done_r  <= done_next_s;
            if (pop_s) begin
                a_r       <= head_s.op;
                d_r       <= head_s.data;
                rsi_r     <= si_map_s[1];
                lsi_r     <= si_map_s[0];
                rep_cnt_r <= load_rep_s;
            end else if (dec_s) begin
                rep_cnt_r <= rep_cnt_r - CNT_W'(1);
            end else if (hold_s) begin
                a_r <= OP_HOLD;
            end
        end
    end

    assign A        = a_r;
    assign D        = d_r;
    assign RSI      = rsi_r;
    assign LSI      = lsi_r;
    assign cmd_done = done_r;
    assign busy     = (state_r == ST_ISSUE) || !empty_s;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Self-checking bench for usr_cmd_sequencer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_usr_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [5:0]       cmd_data;
    logic [CNT_W-1:0] cmd_rep;
    logic             cmd_si;
    logic [2:0]       A;
    logic [5:0]       D;
    logic             RSI;
    logic             LSI;
    logic             busy;
    logic             cmd_done;
    bit               cur_ab = 1'b0;

`ifdef USR_SEQ_ABORT_EN
    logic abort;
    assign abort = cur_ab;
`endif

    always #5 Clk = ~Clk;

    usr_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_rep   (cmd_rep),
        .cmd_si    (cmd_si),
`ifdef USR_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .A         (A),
        .D         (D),
        .RSI       (RSI),
        .LSI       (LSI),
        .busy      (busy),
        .cmd_done  (cmd_done)
    );

    typedef struct {
        logic [2:0] op;
        logic [5:0] data;
        logic [3:0] rep;
        logic       si;
    } mcmd_t;

    typedef struct {
        logic       v;
        mcmd_t      c;
        logic [2:0] a;
        logic [5:0] d;
        logic       rsi;
        logic       lsi;
        logic       done;
        logic       ready;
        logic       busy;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: accepted-command queue plus cycles left on the command on A.
    mcmd_t      mq[$];
    bit         m_active;
    int         m_left;
    logic [2:0] m_a;
    logic [5:0] m_d;
    logic       m_rsi;
    logic       m_lsi;

    function automatic mcmd_t mk(input logic [2:0] op, input logic [5:0] data,
                                 input logic [3:0] rep, input logic si);
        mcmd_t c;
        c.op = op; c.data = data; c.rep = rep; c.si = si;
        return c;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready(input bit ab);
        return (mq.size() < DEPTH) && !ab;
    endfunction

    task automatic mdl_reset();
        mq.delete();
        m_active = 1'b0; m_left = 0;
        m_a = 3'd0; m_d = 6'd0; m_rsi = 1'b0; m_lsi = 1'b0;
    endtask

    task automatic mdl_step(input bit v, input mcmd_t c, input bit ab);
        bit    acc;
        mcmd_t cur;
        acc = v && m_ready(ab);
        if (ab) begin
            mq.delete();
            m_active = 1'b0;
            m_a = 3'd0;
        end else begin
            if (m_active && m_left > 1) begin
                m_left--;
            end else if (mq.size() > 0) begin
                cur      = mq.pop_front();
                m_active = 1'b1;
                m_left   = int'(cur.rep) + 1;
                m_a      = cur.op;
                m_d      = cur.data;
                m_rsi    = (cur.op == 3'b001) && cur.si;
                m_lsi    = (cur.op == 3'b010) && cur.si;
            end else begin
                m_active = 1'b0;
                m_a = 3'd0;
            end
            if (acc) mq.push_back(c);
        end
    endtask

    task automatic mdl_check(input string tag);
        chk({tag, "_A"}, 8'(A), 8'(m_a));
        chk({tag, "_D"}, 8'(D), 8'(m_d));
        chk({tag, "_RSI"}, 8'(RSI), 8'(m_rsi));
        chk({tag, "_LSI"}, 8'(LSI), 8'(m_lsi));
        chk({tag, "_done"}, 8'(cmd_done), 8'(m_active && m_left == 1));
        chk({tag, "_busy"}, 8'(busy), 8'(m_active || mq.size() > 0));
        chk({tag, "_ready"}, 8'(cmd_ready), 8'(m_ready(cur_ab)));
    endtask

    task automatic drive(input bit v, input mcmd_t c, input bit ab);
        cmd_valid = v;
        cmd_op    = c.op;
        cmd_data  = c.data;
        cmd_rep   = c.rep;
        cmd_si    = c.si;
        cur_ab    = ab;
    endtask

    task automatic cyc(input bit v, input mcmd_t c, input bit ab, input string tag);
        drive(v, c, ab);
        @(negedge Clk);
        mdl_check(tag);
        @(posedge Clk);
        mdl_step(v, c, ab);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, mk(3'd0, 6'd0, 4'd0, 1'b0), 1'b0, tag);
    endtask

    task automatic push_wait(input mcmd_t c, input string tag, output int waits);
        bit got;
        bit acc;
        got = 1'b0;
        waits = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            acc = m_ready(1'b0);
            cyc(1'b1, c, 1'b0, tag);
            if (acc) got = 1'b1;
            else waits++;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_accept: got no accept expected accept within 64 cycles", tag);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && (m_active || mq.size() > 0); i++) idle(1, tag);
        chk({tag, "_drained"}, 8'(busy), 8'd0);
    endtask

    vec_t tv[14];
    int   w;
    int   wsum;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // {v, cmd, A, D, RSI, LSI, done, ready, busy}
        tv[0]  = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[1]  = '{1'b1, mk(3'd7, 6'h2A, 4'd0, 1'b0), 3'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[3]  = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd7, 6'h2A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tv[4]  = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd0, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b1, mk(3'd1, 6'h00, 4'd3, 1'b1), 3'd0, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b1, mk(3'd5, 6'h15, 4'd1, 1'b0), 3'd0, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[7]  = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd1, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[8]  = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd1, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[9]  = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd1, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[10] = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd1, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tv[11] = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd5, 6'h15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[12] = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd5, 6'h15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tv[13] = '{1'b0, mk(3'd0, 6'h00, 4'd0, 1'b0), 3'd0, 6'h15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        drive(1'b0, mk(3'd0, 6'd0, 4'd0, 1'b0), 1'b0);
        mdl_reset();
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b0;

        // Directed table: reset state, single Load, back-to-back shift/inc
        for (int i = 0; i < 14; i++) begin
            drive(tv[i].v, tv[i].c, 1'b0);
            @(negedge Clk);
            chk($sformatf("tbl%0d_A", i), 8'(A), 8'(tv[i].a));
            chk($sformatf("tbl%0d_D", i), 8'(D), 8'(tv[i].d));
            chk($sformatf("tbl%0d_RSI", i), 8'(RSI), 8'(tv[i].rsi));
            chk($sformatf("tbl%0d_LSI", i), 8'(LSI), 8'(tv[i].lsi));
            chk($sformatf("tbl%0d_done", i), 8'(cmd_done), 8'(tv[i].done));
            chk($sformatf("tbl%0d_ready", i), 8'(cmd_ready), 8'(tv[i].ready));
            chk($sformatf("tbl%0d_busy", i), 8'(busy), 8'(tv[i].busy));
            @(posedge Clk);
            mdl_step(tv[i].v, tv[i].c, 1'b0);
            #1;
        end

        // Backpressure: long first command, then DEPTH+1 more pushes
        push_wait(mk(3'd3, 6'h11, 4'd15, 1'b0), "bp0", w);
        wsum = 0;
        for (int k = 0; k < 5; k++) begin
            push_wait(mk(3'(k + 1), 6'(k * 9 + 3), 4'(k % 3), 1'b1), $sformatf("bp%0d", k + 1), w);
            if (k < 4) wsum += w;
            if (k == 4) chk("bp_fifth_waited", 8'(w > 0), 8'd1);
            if (k == 3) begin
                drive(1'b0, mk(3'd0, 6'd0, 4'd0, 1'b0), 1'b0);
                @(negedge Clk);
                chk("bp_ready_low_when_full", 8'(cmd_ready), 8'd0);
                chk("bp_busy_when_full", 8'(busy), 8'd1);
                @(posedge Clk);
                mdl_step(1'b0, mk(3'd0, 6'd0, 4'd0, 1'b0), 1'b0);
                #1;
            end
        end
        chk("bp_first_four_no_wait", 8'(wsum), 8'd0);
        drain("bp_drain");

        // Reset mid-ISSUE with three entries queued
        push_wait(mk(3'd6, 6'h3F, 4'd7, 1'b0), "rst0", w);
        for (int k = 0; k < 3; k++) push_wait(mk(3'd2, 6'h05, 4'd2, 1'b1), "rstq", w);
        idle(1, "rst_pre");
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_A", 8'(A), 8'd0);
        chk("rst_async_D", 8'(D), 8'd0);
        chk("rst_async_RSI", 8'(RSI), 8'd0);
        chk("rst_async_LSI", 8'(LSI), 8'd0);
        chk("rst_async_done", 8'(cmd_done), 8'd0);
        chk("rst_async_busy", 8'(busy), 8'd0);
        @(posedge Clk);
        #1;
        reset = 1'b0;
        mdl_reset();
        idle(3, "rst_post");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 6),
                mk(3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
                   ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1))),
                1'b0, "rnd");
        end
        drain("rnd_drain");

`ifdef USR_SEQ_ABORT_EN
        // Abort during a rep=7 issue with two commands queued
        push_wait(mk(3'd4, 6'h0A, 4'd7, 1'b0), "ab0", w);
        push_wait(mk(3'd5, 6'h0B, 4'd1, 1'b0), "ab1", w);
        push_wait(mk(3'd6, 6'h0C, 4'd1, 1'b0), "ab2", w);
        idle(2, "ab_pre");
        cyc(1'b1, mk(3'd7, 6'h3C, 4'd0, 1'b0), 1'b1, "ab_cycle");
        drive(1'b0, mk(3'd0, 6'd0, 4'd0, 1'b0), 1'b0);
        @(negedge Clk);
        chk("ab_after_A", 8'(A), 8'd0);
        chk("ab_after_done", 8'(cmd_done), 8'd0);
        chk("ab_after_busy", 8'(busy), 8'd0);
        chk("ab_after_ready", 8'(cmd_ready), 8'd1);
        @(posedge Clk);
        mdl_step(1'b0, mk(3'd0, 6'd0, 4'd0, 1'b0), 1'b0);
        #1;
        idle(4, "ab_post");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usr_cmd_sequencer.md
# usr_cmd_sequencer

Upstream command sequencer for the 6-bit universal shift register. It accepts opcode/data/repeat commands over a valid/ready handshake and buffers them in a small FIFO. It then drives the register's control code A, parallel data D and shift-in bits RSI/LSI, holding each opcode for a programmed number of clock cycles. When no command is pending, A is driven to Hold (000).

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2
- CNT_W, 4: repeat-count width
- Clk  in  1  positive-edge clock
- reset  in  1  asynchronous, active-high; clears FIFO, FSM and all outputs
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; transfer on Clk edge when cmd_valid & cmd_ready
- cmd_op  in  3  opcode for A (000 Hold … 111 Load)
- cmd_data  in  6  value for D (meaningful for Load)
- cmd_rep  in  CNT_W  issue count minus one (0 → 1 cycle)
- cmd_si  in  1  shift-in bit; driven on RSI for op 001 and on LSI for op 010
- A  out  3  control code to the shift register
- D  out  6  parallel data to the shift register
- RSI  out  1  right-shift-in bit
- LSI  out  1  left-shift-in bit
- busy  out  1  FSM in ISSUE or FIFO non-empty
- cmd_done  out  1  one-cycle pulse on the final issue cycle of each command
- abort  in  1  synchronous flush; present only with USR_SEQ_ABORT_EN

## Operation
- FSM states: IDLE and ISSUE.
- **IDLE**
  - A=000, D, RSI and LSI hold their last values, cmd_done=0.
  - If the FIFO is non-empty: pop, load A/D/RSI/LSI from the entry, load rep_cnt=cmd_rep, go to ISSUE.
- **ISSUE**
  - If rep_cnt≠0: decrement and keep outputs.
  - If rep_cnt=0 (final cycle, cmd_done=1): if the FIFO is non-empty, pop the next entry directly, with no Hold gap. Otherwise go to IDLE and drive A=000 next cycle.
- **Shift-in mapping**
  - RSI=cmd_si when op=001, otherwise 0.
  - LSI=cmd_si when op=010, otherwise 0.
- **FIFO**
  - DEPTH entries of {op, data, rep, si}; write/read pointers have one extra wrap bit.
  - full when pointers differ only in the MSB; empty when equal.
  - cmd_ready = !full. Writes while full are impossible by handshake.
  - Simultaneous push and pop while full: the pop frees a slot at the same edge, but cmd_ready is still 0 that cycle, so the push does not happen.
  - Simultaneous push and pop while empty: no bypass; the pushed entry is issued the following cycle.
- Repeat count: CNT_W bits, no saturation needed; cmd_rep=2^CNT_W−1 yields 2^CNT_W issue cycles.
- busy = (state==ISSUE) | !empty.

## Timing
- A, D, RSI, LSI and cmd_done are registered; all reset to 0. FSM resets to IDLE, pointers to 0.
- Latency: a command accepted at edge k appears on A after edge k+1 if the FSM is idle; the shift register acts on it at edge k+2.
- A command stays on A for exactly cmd_rep+1 consecutive cycles.
- Back-to-back commands issue with zero gap cycles.
- Reset mid-ISSUE: outputs go to 0 immediately (asynchronous) and queued commands are lost.

## Configuration
- **USR_SEQ_ABORT_EN defined**
  - Adds the abort input.
  - abort=1 at an edge empties the FIFO, ends any command without a cmd_done pulse, forces IDLE and A=000.
  - cmd_ready=0 while abort=1.
  - abort has priority over pop and push in the same cycle.
- **USR_SEQ_ABORT_EN undefined**
  - The port and its logic are absent.
  - A command can only be terminated by reset.

## Structure
- **Package usr_pkg:**
  - opcode localparams OP_HOLD, OP_SHL, OP_SHR, OP_CLR, OP_SET, OP_INC, OP_DEC, OP_LOAD
  - the packed command struct usr_cmd_t {op, data, rep, si}
  - FSM state enum
- **Sub-module usr_cmd_fifo:** parameterised synchronous FIFO (DEPTH, width of usr_cmd_t) with push/pop/full/empty. It holds no FSM logic.

## Test plan
- Reset, then idle → A=000, D=0, RSI=LSI=0, cmd_ready=1, busy=0.
- Push {op=111, data=6'h2A, rep=0} → A=111 and D=2A for exactly one cycle after one cycle of latency; cmd_done pulses once; the downstream register then reads 2A.
- Push {op=001, si=1, rep=3} then {op=101, rep=1} back-to-back → A=001 with RSI=1 for 4 cycles, then A=101 for 2 cycles, no gap, then 000; cmd_done pulses twice.
- Hold pops off (first command rep=15) and push 5 more commands → cmd_ready drops after DEPTH are queued; the 5th is accepted only after a pop; all commands issue in order.
- Assert reset mid-ISSUE with 3 entries queued → outputs 0 immediately; after release busy=0 and A=000.
- With USR_SEQ_ABORT_EN: abort during ISSUE of rep=7 with 2 queued → A=000 next cycle, no cmd_done, FIFO empty, busy=0.
